// File: rtl/dynode_evtdet_gen_if.sv
// Event output handshake of the dynode event detector: a registered
// event slot offered by the detector and accepted by the consumer.
interface dynode_evtdet_gen_if #(
    parameter int TIM_W  = 8,
    parameter int FRAC_W = 12
);
    logic                    evt_valid;
    logic                    evt_ready;
    logic [TIM_W+FRAC_W-1:0] evt_time;
    logic                    evt_pile;

    modport master (
        output evt_valid,
        output evt_time,
        output evt_pile,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_time,
        input  evt_pile,
        output evt_ready
    );
endinterface

// File: rtl/dynode_evtdet_gen.sv
// Dynode event detector: boxcar smoothing, hysteresis presence flag and
// leading-edge timing with a sequential restoring divider for the sub-cycle fraction.
module dynode_evtdet_gen #(
    parameter int ADC_W  = 12,
    parameter int TIM_W  = 8,
    parameter int FRAC_W = 12,
    parameter int DEAD_W = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [ADC_W-1:0]        din,
    input  logic [TIM_W-1:0]        timcnt,
    input  logic [1:0]              smooth_n,
    input  logic [ADC_W+1:0]        thr_on,
    input  logic [ADC_W+1:0]        thr_off,
    input  logic [ADC_W+1:0]        thr_cross,
    input  logic [TIM_W+FRAC_W-1:0] time_adj,
    input  logic [DEAD_W-1:0]       dead_len,
    output logic                    dyn_indet,
    output logic                    pileup_det,
    output logic [7:0]              drop_cnt,
    dynode_evtdet_gen_if.master     evt
);
    localparam int SW = ADC_W + 2;
    localparam int EW = TIM_W + FRAC_W;
    localparam int CW = $clog2(FRAC_W + 1);
    localparam logic [CW-1:0]     BIT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]     BIT_LAST = CW'(FRAC_W - 1);
    localparam logic [DEAD_W-1:0] DEAD_ONE = {{(DEAD_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) return v;
        else            return v + 8'd1;
    endfunction

    logic [ADC_W-1:0]  hist_q [4];
    logic [SW-1:0]     s_q, s_prev_q, sum_s;
    logic              indet_q;
    state_e            state_q, state_d;
    logic [TIM_W-1:0]  coarse_q, coarse_d;
    logic [SW-1:0]     den_q, den_d, rem_q, rem_d, rem_nx_s;
    logic [FRAC_W-2:0] quo_q, quo_d;
    logic [CW-1:0]     bit_q, bit_d;
    logic              pile_q, pile_d;
    logic [DEAD_W-1:0] dead_q, dead_d;
    logic              pileup_q, pileup_d;
    logic              valid_q, valid_d;
    logic [EW-1:0]     time_q, time_d;
    logic              epile_q, epile_d;
    logic [7:0]        drop_q, drop_d;
    logic [SW:0]       trial_s;
    logic              qbit_s, x_s, last_s;
    logic [FRAC_W-1:0] frac_s;
    logic [EW-1:0]     t_s;

    // Boxcar sum over the newest smooth_n+1 history samples.
    always_comb begin
        sum_s = {SW{1'b0}};
        for (int i = 0; i < 4; i++) begin
            if (2'(i) <= smooth_n) sum_s = sum_s + SW'(hist_q[i]);
            else                   sum_s = sum_s;
        end
    end

    // Sample history, smoothed value, its delayed copy and the hysteresis flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) hist_q[i] <= {ADC_W{1'b0}};
            s_q      <= {SW{1'b0}};
            s_prev_q <= {SW{1'b0}};
            indet_q  <= 1'b0;
        end else begin
            hist_q[0] <= din;
            for (int i = 1; i < 4; i++) hist_q[i] <= hist_q[i-1];
            s_q      <= sum_s;
            s_prev_q <= s_q;
            indet_q  <= indet_q ? (s_q > thr_off) : (s_q > thr_on);
        end
    end

    // Crossing detect and one restoring-division step (remainder always stays below den).
    always_comb begin
        x_s     = (s_prev_q <= thr_cross) && (s_q > thr_cross);
        trial_s = {rem_q, 1'b0};
        qbit_s  = (trial_s >= {1'b0, den_q});
        if (qbit_s) rem_nx_s = SW'(trial_s - {1'b0, den_q});
        else        rem_nx_s = trial_s[SW-1:0];
        frac_s  = {quo_q, qbit_s};
        last_s  = (bit_q == BIT_LAST);
        t_s     = {coarse_q, frac_s} + time_adj;
    end

    // Next-state logic for the detector FSM and the output event slot.
    always_comb begin
        state_d  = state_q;
        coarse_d = coarse_q;
        den_d    = den_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        bit_d    = bit_q;
        pile_d   = pile_q;
        dead_d   = dead_q;
        valid_d  = valid_q & ~evt.evt_ready;
        time_d   = time_q;
        epile_d  = epile_q;
        drop_d   = drop_q;
        pileup_d = en && x_s && (state_q != ST_IDLE);
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (x_s) begin
                        state_d  = ST_DIV;
                        coarse_d = timcnt;
                        rem_d    = thr_cross - s_prev_q;
                        den_d    = s_q - s_prev_q;
                        quo_d    = {(FRAC_W-1){1'b0}};
                        bit_d    = {CW{1'b0}};
                        pile_d   = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DIV: begin
                    rem_d  = rem_nx_s;
                    quo_d  = frac_s[FRAC_W-2:0];
                    bit_d  = bit_q + BIT_ONE;
                    pile_d = pile_q | x_s;
                    if (last_s) begin
                        state_d = ST_HOLD;
                        dead_d  = dead_len;
                        // A same-cycle accept frees the slot for this event.
                        if (!valid_q || evt.evt_ready) begin
                            valid_d = 1'b1;
                            time_d  = t_s;
                            epile_d = pile_q | x_s;
                        end else begin
                            drop_d = sat_inc8(drop_q);
                        end
                    end else begin
                        state_d = ST_DIV;
                    end
                end
                ST_HOLD: begin
                    if (dead_q != {DEAD_W{1'b0}}) dead_d = dead_q - DEAD_ONE;
                    else                          dead_d = dead_q;
                    if ((dead_q == {DEAD_W{1'b0}}) && (s_q <= thr_off)) state_d = ST_IDLE;
                    else                                                 state_d = ST_HOLD;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Detector state and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            coarse_q <= {TIM_W{1'b0}};
            den_q    <= {SW{1'b0}};
            rem_q    <= {SW{1'b0}};
            quo_q    <= {(FRAC_W-1){1'b0}};
            bit_q    <= {CW{1'b0}};
            pile_q   <= 1'b0;
            dead_q   <= {DEAD_W{1'b0}};
            pileup_q <= 1'b0;
            valid_q  <= 1'b0;
            time_q   <= {EW{1'b0}};
            epile_q  <= 1'b0;
            drop_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            coarse_q <= coarse_d;
            den_q    <= den_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            bit_q    <= bit_d;
            pile_q   <= pile_d;
            dead_q   <= dead_d;
            pileup_q <= pileup_d;
            valid_q  <= valid_d;
            time_q   <= time_d;
            epile_q  <= epile_d;
            drop_q   <= drop_d;
        end
    end

    assign dyn_indet     = indet_q;
    assign pileup_det    = pileup_q;
    assign drop_cnt      = drop_q;
    assign evt.evt_valid = valid_q;
    assign evt.evt_time  = time_q;
    assign evt.evt_pile  = epile_q;
endmodule

// File: doc/dynode_evtdet_gen.md
Name: dynode_evtdet_gen

Overview:
- Parametrised next-generation dynode event detector for the ROCSTAR dynode trigger path.
- Smooths the baseline-corrected dynode ADC stream with a runtime-selectable boxcar and tracks signal presence with hysteresis.
- Timestamps each leading-edge threshold crossing as coarse counter plus linearly interpolated sub-cycle fraction. The fraction comes from a sequential restoring divider, so no inverse lookup table is needed.
- Adds deadtime, pileup flagging, a valid/ready output handshake and drop counting.

Parameters:
- ADC_W, 12: baseline-corrected sample width (unsigned).
- TIM_W, 8: coarse time counter width.
- FRAC_W, 12: fraction bits; also the divider cycle count.
- DEAD_W, 6: deadtime counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- en  in  1  detector enable; 0 forces IDLE.
- din  in  ADC_W  baseline-corrected dynode sample, one per clk.
- timcnt  in  TIM_W  free-running coarse time counter.
- smooth_n  in  2  boxcar length minus 1 (0..3 gives 1..4 points).
- thr_on  in  ADC_W+2  indet turn-on level.
- thr_off  in  ADC_W+2  indet turn-off level and HOLD release level.
- thr_cross  in  ADC_W+2  timing crossing level.
- time_adj  in  TIM_W+FRAC_W  constant added to the event time, modulo 2^(TIM_W+FRAC_W).
- dead_len  in  DEAD_W  minimum HOLD cycles.
- dyn_indet  out  1  signal-present flag (hysteresis).
- pileup_det  out  1  one-cycle pulse on a crossing outside IDLE.
- evt_valid  out  1  output event register full.
- evt_ready  in  1  consumer accept.
- evt_time  out  TIM_W+FRAC_W  adjusted event time.
- evt_pile  out  1  pileup occurred during this event's DIV.
- drop_cnt  out  8  saturating count of events lost to a full output register.

Behaviour:
- Reset: all outputs, history, S, S_prev, state, counters and the output register go to 0. State goes to IDLE. Reset during DIV or HOLD aborts with no output.
- Smoothing:
  - History holds 4 samples.
  - din sampled at edge k enters the history. S (width ADC_W+2) at edge k+1 is the sum of the newest smooth_n+1 samples.
  - S_prev is S delayed one clk.
- dyn_indet: if 0, set to (S > thr_on); if 1, set to (S > thr_off). Updated every clk, registered.
- Crossing condition X: (S_prev <= thr_cross) and (S > thr_cross), evaluated on registered values.
- State machine:
  - IDLE:
    - If en and X: capture coarse = timcnt, num = thr_cross - S_prev, den = S - S_prev (num < den is guaranteed), and pile = 0. Go to DIV.
  - DIV:
    - Restoring division, one quotient bit per clk, MSB first. Runs exactly FRAC_W cycles and gives frac = floor(num * 2^FRAC_W / den).
    - X during DIV sets pile and pulses pileup_det.
    - On the last bit, compute t = {coarse, frac} + time_adj.
      - If evt_valid = 0 or evt_ready = 1 that cycle: load evt_time = t and evt_pile = pile, and set evt_valid.
      - Otherwise: drop the event and increment drop_cnt, saturating at 255.
    - Load dead counter = dead_len. Go to HOLD.
  - HOLD:
    - Dead counter decrements to 0.
    - Exit to IDLE when the counter is 0 and S <= thr_off.
    - X in HOLD pulses pileup_det; the emitted event is not modified.
- Latency: with X true after edge c, the state enters DIV at edge c+1 (timcnt sampled at edge c+1) and evt_valid rises at edge c+1+FRAC_W.
- Handshake:
  - evt_valid stays high until a cycle with evt_ready = 1, then clears.
  - A simultaneous accept and new load keeps evt_valid = 1 with the new data.
  - evt_time and evt_pile hold stable while valid.
- en = 0: the next edge forces IDLE and aborts DIV/HOLD without output. Smoothing and dyn_indet keep running. The output register and drop_cnt are retained.
- Config ports are sampled live; changes are only guaranteed safe while en = 0.

Test Plan:
- FRAC_W=12, smooth_n=0, thr_cross=100, time_adj=0; din 50 then 150, timcnt=0x37 at the DIV-entry edge -> evt_valid exactly FRAC_W cycles later, evt_time=0x37800, evt_pile=0.
- din 100 then 300, thr_cross=100 (num=0) -> frac=0x000. din 0 then 101 (num=100, den=101) -> frac=0xFD7.
- timcnt=0xFF, frac=0x800, time_adj=0x00900 -> evt_time=0x00100 (wrap).
- evt_ready held 0, three separated pulses -> first event held unchanged, drop_cnt=2; then one cycle of evt_ready=1 -> evt_valid=0.
- Second crossing 4 cycles into DIV -> pileup_det one-cycle pulse, evt_pile=1. Crossing in HOLD with dead_len=20 -> pulse only, no second event.
- Reset asserted (or en=0) mid-DIV -> no evt_valid, state IDLE, drop_cnt unchanged by en=0; smooth_n=3 with din constant 50 -> S=200 after 4 samples, dyn_indet per thr_on/thr_off hysteresis.
